// File: rtl/rotate_seq_pkg.sv
// Shared types and constants for the rotate-register sequencer.
// The ROT_AMT_MOD_EN build uses amt_mod() to reduce rotate amounts.
package rotate_seq_pkg;

  localparam int STATE_W = 3;
  localparam int DEF_DW  = 4;
  localparam int DEF_AW  = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ROT  = 3'd2,
    CAPT = 3'd3,
    RESP = 3'd4
  } state_t;

  // A rotation by amt equals a rotation by amt mod width.
  function automatic int unsigned amt_mod(input int unsigned amt, input int unsigned dw);
    return amt % dw;
  endfunction

endpackage

// File: rtl/rot_step_cnt.sv
// Loadable down-counter that tracks the rotate steps still owed to the register.
// The count saturates at zero, and clr forces it to zero.
module rot_step_cnt #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic          dec,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] cnt,
  output logic          zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - AW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rotate_seq_ctrl.sv
// Sequencer that loads, steps and captures an external DW-bit right-rotate register.
// Optional build macro ROT_AMT_MOD_EN reduces the amount mod DW to give fewer en pulses.
module rotate_seq_ctrl
  import rotate_seq_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_data,
  input  logic [AW-1:0] cmd_amt,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic          rr_sync_rst,
  output logic          rr_load,
  output logic          rr_en,
  output logic [DW-1:0] rr_data,
  input  logic [DW-1:0] rr_q
);

  state_t        state;
  logic [AW-1:0] steps;
  logic [AW-1:0] amt_eff;
  logic          steps_zero;
  logic          accept;

  assign cmd_ready = (state == IDLE) && !clr;
  assign accept    = cmd_valid && cmd_ready;

`ifdef ROT_AMT_MOD_EN
  assign amt_eff = AW'(amt_mod(32'(cmd_amt), DW));
`else
  assign amt_eff = cmd_amt;
`endif

  rot_step_cnt #(.AW(AW)) u_step_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (accept),
    .dec      ((state == ROT) && !clr),
    .load_val (amt_eff),
    .cnt      (steps),
    .zero     (steps_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_data  <= '0;
      rsp_data <= '0;
    end else if (clr) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rr_data <= cmd_data;
            state   <= LOAD;
          end
        end
        LOAD: state <= steps_zero ? CAPT : ROT;
        // The final en pulse is issued in the cycle that sees one step left.
        ROT: begin
          if (steps == AW'(1)) state <= CAPT;
        end
        CAPT: begin
          rsp_data <= rr_q;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // clr overrides the decoded controls in the same cycle so that sync_rst stands alone.
  assign rr_sync_rst = clr;
  assign rr_load     = (state == LOAD) && !clr;
  assign rr_en       = (state == ROT) && !clr;
  assign rsp_valid   = (state == RESP);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Directed and random bench for rotate_seq_ctrl driving a behavioural rotate register.
// Its expectations follow ROT_AMT_MOD_EN when that macro is defined.
module tb_rotate_seq_ctrl;
  localparam int DW = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n, clr, cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic          rr_sync_rst, rr_load, rr_en;
  logic [DW-1:0] cmd_data, rsp_data, rr_data, rr_q;
  logic [AW-1:0] cmd_amt;

  int checks   = 0;
  int failures = 0;
  int en_cnt   = 0;
  int load_cnt = 0;
  int overlap  = 0;

  always #5 clk = ~clk;

  rotate_seq_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_amt(cmd_amt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
    .rr_sync_rst(rr_sync_rst), .rr_load(rr_load), .rr_en(rr_en), .rr_data(rr_data), .rr_q(rr_q)
  );

  // Behavioural right-rotate register: sync_rst > load > en.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           rr_q <= '0;
    else if (rr_sync_rst) rr_q <= '0;
    else if (rr_load)     rr_q <= rr_data;
    else if (rr_en)       rr_q <= {rr_q[0], rr_q[DW-1:1]};
  end

  always @(posedge clk) begin
    if (rr_en) en_cnt++;
    if (rr_load) load_cnt++;
    if (rr_load && rr_en) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] d, input int r);
    int v;
    v = (int'(d) * (1 << DW) + int'(d)) >> r;
    return DW'(v % (1 << DW));
  endfunction

  function automatic int exp_pulses(input int a);
`ifdef ROT_AMT_MOD_EN
    return a % DW;
`else
    return a;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [DW-1:0] d, input logic [AW-1:0] a, input int hold,
                         input string tag);
    int            en0, ld0, lat, pulses;
    logic [DW-1:0] exp;
    pulses = exp_pulses(int'(a));
    exp    = rotr(d, int'(a) % DW);
    @(negedge clk);
    cmd_data = d; cmd_amt = a; cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    check({tag, "_ready"}, 32'(cmd_ready), 32'(1));
    en0 = en_cnt; ld0 = load_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(3 + pulses));
    check({tag, "_data"}, 32'(rsp_data), 32'(exp));
    check({tag, "_en_pulses"}, 32'(en_cnt - en0), 32'(pulses));
    check({tag, "_load_pulses"}, 32'(load_cnt - ld0), 32'(1));
    check({tag, "_busy"}, 32'(busy), 32'(1));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'(1));
      check({tag, "_hold_data"}, 32'(rsp_data), 32'(exp));
      check({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'(0));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'(0));
    check({tag, "_idle_ready"}, 32'(cmd_ready), 32'(1));
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_data = '0; cmd_amt = '0;
    #2;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(0));
    check("rst_rr_data", 32'(rr_data), 32'(0));
    check("rst_ctrl", 32'({rr_load, rr_en, rr_sync_rst}), 32'(0));
    check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_cmd(4'b1001, 4'd1, 0, "amt1");
    run_cmd(4'b1001, 4'd0, 0, "amt0");
    run_cmd(4'b1001, 4'd6, 0, "amt6");
    run_cmd(4'b1001, 4'd3, 5, "hold5");

    // clr in the third ROT cycle
    @(negedge clk);
    cmd_data = 4'b1011; cmd_amt = 4'd7; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("clr_pre_en", 32'(rr_en), 32'(1));
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr_sync_rst", 32'(rr_sync_rst), 32'(1));
    check("clr_ctrl_off", 32'({rr_load, rr_en}), 32'(0));
    check("clr_cmd_ready", 32'(cmd_ready), 32'(0));
    @(posedge clk); #1;
    check("clr_rr_q", 32'(rr_q), 32'(0));
    check("clr_busy", 32'(busy), 32'(0));
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("clr_sync_rst_drop", 32'(rr_sync_rst), 32'(0));
    repeat (4) begin
      @(posedge clk); #1;
      check("clr_no_rsp", 32'(rsp_valid), 32'(0));
    end

    // clr beats a simultaneous command in IDLE
    @(negedge clk);
    clr = 1'b1; cmd_valid = 1'b1; cmd_amt = 4'd2;
    #1;
    check("clr_vs_cmd_ready", 32'(cmd_ready), 32'(0));
    @(posedge clk); #1;
    check("clr_vs_cmd_busy", 32'(busy), 32'(0));
    @(negedge clk);
    clr = 1'b0; cmd_valid = 1'b0;

    // asynchronous reset during ROT
    @(negedge clk);
    cmd_data = 4'b0110; cmd_amt = 4'd7; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_ctrl", 32'({rr_load, rr_en, rr_sync_rst, rsp_valid}), 32'(0));
    check("arst_rr_data", 32'(rr_data), 32'(0));
    check("arst_cmd_ready", 32'(cmd_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(4'b0101, 4'd2, 1, "post_rst");

    for (int i = 0; i < 10; i++) begin
      run_cmd(DW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
              int'($urandom_range(0, 2)), "rand");
    end

    check("load_en_overlap", 32'(overlap), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
